// File: rtl/tdm_pkg.sv
// Shared constants and slot encoding for the 4-lane TDM demultiplexer.
package tdm_pkg;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } slot_t;
endpackage

// File: rtl/tdm_demux4_if.sv
// Serial beat bus feeding the TDM demultiplexer.
interface tdm_demux4_if #(parameter int WIDTH = 2) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_sof;

  modport master (output in_data, in_valid, in_sof);
  modport slave  (input  in_data, in_valid, in_sof);
endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot FSM: advances on each valid beat, wraps S3->S0, realign forces lane a taken (-> S1).
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  advance,
  input  logic  realign,
  output slot_t slot,
  output logic  wrap
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       slot <= S0;
    else if (realign) slot <= S1;
    else if (advance) slot <= slot_t'(slot + 2'd1);
  end

  // Realign beat in S3 is lane a of a new frame, not the end of the old one.
  assign wrap = advance & ~realign & (slot == S3);
endmodule

// File: rtl/tdm_demux4.sv
// Receiving end of a 4:1 TDM link: collects four beats into lanes a..d.
// Optional saturating error counter enabled by `define TDM_DEMUX_ERRCNT_EN.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  tdm_demux4_if.slave      bus,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [1:0]       slot
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);
  slot_t slot_q;
  logic  wrap;
  logic  realign;

  // Lane d never needs a shadow: its beat completes the frame directly.
  logic [NUM_LANES-2:0][WIDTH-1:0] shadow;
  logic [NUM_LANES-1:0][WIDTH-1:0] lanes_q;

  assign realign = bus.in_valid & bus.in_sof;

  tdm_slot_ctr u_slot_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (bus.in_valid),
    .realign (realign),
    .slot    (slot_q),
    .wrap    (wrap)
  );

  for (genvar i = 0; i < NUM_LANES - 1; i++) begin : g_shadow
    logic hit;
    assign hit = bus.in_valid & (realign ? (i == 0) : (slot_q == 2'(i)));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   shadow[i] <= '0;
      else if (hit) shadow[i] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= wrap;
      frame_err   <= realign & (slot_q != S0);
      if (wrap) lanes_q <= {bus.in_data, shadow[2], shadow[1], shadow[0]};
    end
  end

  assign a    = lanes_q[0];
  assign b    = lanes_q[1];
  assign c    = lanes_q[2];
  assign d    = lanes_q[3];
  assign slot = slot_q;

`ifdef TDM_DEMUX_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              err_count <= 8'd0;
    else if (frame_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif
endmodule
